// File: rtl/game_pkg.sv
// Shared constants and types for the game timing block.
// Holds the channel limit, default counter width and named divisors.
package game_pkg;

   localparam int NUM_CH_MAX = 8;
   localparam int CNT_W_DEF  = 24;

   localparam logic [CNT_W_DEF-1:0] DIV_VGA_PIX = 24'd54;
   localparam logic [CNT_W_DEF-1:0] DIV_SPI     = 24'd50;
   localparam logic [CNT_W_DEF-1:0] DIV_FRAME   = 24'd1000000;

   // wrap is the combinational pulse that becomes tick on the next edge
   typedef struct packed {
      logic tick;
      logic wrap;
      logic sq;
   } ch_out_t;

endpackage

// File: rtl/game_tick_ch.sv
// One tick channel: divisor counter, pending divisor, tick and square wave.
// The square-wave toggle flop exists only when GAME_TICK_SQ_EN is defined.
module game_tick_ch
   import game_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DIV_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             restart_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] div_i,
   output ch_out_t          out_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pv_q, pv_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] lim;
   logic             wrap;
   logic             sq_w;

   // divisors 0 and 1 both give a one-cycle period
   assign lim  = (div_q == '0) ? '0 : div_q - CNT_W'(1);
   assign wrap = run_i & ~restart_i & (cnt_q >= lim);

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pend_d = pend_q;
      pv_d   = pv_q;
      tick_d = 1'b0;
      if (restart_i) begin
         cnt_d = '0;
         if (we_i) begin
            div_d = div_i;
            pv_d  = 1'b0;
         end else if (pv_q) begin
            div_d = pend_q;
            pv_d  = 1'b0;
         end
      end else begin
         if (run_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
         end
         tick_d = wrap;
         if (wrap) begin
            if (we_i) begin
               div_d = div_i;
               pv_d  = 1'b0;
            end else if (pv_q) begin
               div_d = pend_q;
               pv_d  = 1'b0;
            end
         end else if (we_i) begin
            pend_d = div_i;
            pv_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         div_q  <= DIV_RST;
         pend_q <= '0;
         pv_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         pend_q <= pend_d;
         pv_q   <= pv_d;
         tick_q <= tick_d;
      end
   end

`ifdef GAME_TICK_SQ_EN
   logic sq_q, sq_d;

   always_comb begin
      sq_d = sq_q;
      if (restart_i) begin
         sq_d = 1'b0;
      end else if (wrap) begin
         sq_d = ~sq_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign sq_w = sq_q;
`else
   assign sq_w = 1'b0;
`endif

   assign out_o = '{tick: tick_q, wrap: wrap, sq: sq_w};

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel tick generator with a channel-0 frame counter.
// Define GAME_TICK_SQ_EN to drive 50% square waves on sq.
module game_tick_gen
   import game_pkg::*;
#(
   parameter int                      NUM_CH   = 3,
   parameter int                      CNT_W    = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
      {DIV_FRAME, DIV_SPI, DIV_VGA_PIX},
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              restart,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic [15:0]       tick0_cnt
);

   ch_out_t     ch_out [NUM_CH];
   logic [15:0] tc_q, tc_d;

   // an out-of-range cfg_ch matches no channel, so the write is dropped
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      game_tick_ch #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .run_i     (run),
         .restart_i (restart),
         .we_i      (cfg_we && (cfg_ch == CH_W'(i))),
         .div_i     (cfg_div),
         .out_o     (ch_out[i])
      );
      assign tick[i] = ch_out[i].tick;
      assign sq[i]   = ch_out[i].sq;
   end

   always_comb begin
      tc_d = tc_q;
      if (restart) begin
         tc_d = '0;
      end else if (ch_out[0].wrap) begin
         tc_d = tc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tc_q <= '0;
      end else begin
         tc_q <= tc_d;
      end
   end

   assign tick0_cnt = tc_q;

endmodule

// File: doc/game_tick_gen.md
GAME_TICK_GEN -- requirements
Module: game_tick_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent tick channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 24: divisor and counter width in bits.
REQ-003 SHALL have parameter DIV_INIT, default {24'd1000000, 24'd50, 24'd54}: packed NUM_CH*CNT_W reset divisors, channel 0 in the LSBs.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port run, input, 1 bit: 1 = counters advance; 0 = all counters and outputs hold.
REQ-007 SHALL have port restart, input, 1 bit: synchronous phase realignment of all channels.
REQ-008 SHALL have port cfg_we, input, 1 bit: divisor write strobe.
REQ-009 SHALL have port cfg_ch, input, $clog2(NUM_CH) bits (min 1): channel selected for the write.
REQ-010 SHALL have port cfg_div, input, CNT_W bits: new divisor value.
REQ-011 SHALL have port tick, output, NUM_CH bits: one-cycle clock-enable pulse per channel.
REQ-012 SHALL have port sq, output, NUM_CH bits: 50 %-duty square wave per channel.
REQ-013 SHALL have port tick0_cnt, output, 16 bits: count of channel-0 ticks (frame counter).

Function
REQ-014 SHALL keep a per-channel counter cnt[i] that counts 0..div[i]-1, then wraps to 0.
REQ-015 SHALL register tick[i] high for exactly one cycle, in the cycle after cnt[i] wraps, while run=1.
REQ-016 SHALL deliver the first tick[i] exactly div[i] cycles after the first run=1 edge following reset or restart; period is div[i] cycles.
REQ-017 SHALL treat div[i] of 0 or 1 as 1, so tick[i] stays high every cycle while run=1.
REQ-018 SHALL, when run=0, hold cnt, sq and tick0_cnt and drive tick to 0.
REQ-019 SHALL, on restart=1, clear every cnt, tick, sq and tick0_cnt in that cycle regardless of run.
REQ-020 SHALL, on cfg_we=1 with cfg_ch < NUM_CH, store cfg_div in a pending register for that channel.
REQ-021 SHALL ignore cfg_we when cfg_ch >= NUM_CH.
REQ-022 SHALL apply a pending divisor at that channel's next wrap, so the period in progress completes at the old divisor; no runt or stretched period.
REQ-023 SHALL apply a pending divisor immediately when cfg_we coincides with restart or with a wrap.
REQ-024 SHALL let the last write win when several writes to one channel occur before its wrap.
REQ-025 SHALL increment tick0_cnt modulo 2^16 on each tick[0], wrapping from 0xFFFF to 0x0000.
REQ-026 SHALL keep all arithmetic unsigned and CNT_W wide; counter compare uses div-1 saturated at 0.

Reset
REQ-027 SHALL, on rst=0, asynchronously set cnt=0, tick=0, sq=0, tick0_cnt=0, div=DIV_INIT and clear pending writes.
REQ-028 SHALL abandon any in-progress period and pending write when reset is asserted mid-operation; counting resumes from 0 after release.

Configuration
REQ-029 SHALL use macro GAME_TICK_SQ_EN: when defined, sq[i] toggles on every tick[i], giving a 2*div[i]-cycle period (e.g. an SPI serial clock for the audio path).
REQ-030 SHALL, when GAME_TICK_SQ_EN is undefined, keep the sq port, tie it to 0 and synthesise no toggle flops.

Structure
REQ-031 SHALL place the following in shared package game_pkg: the NUM_CH maximum (8), the default CNT_W, and named divisor constants DIV_VGA_PIX, DIV_SPI and DIV_FRAME.
REQ-032 SHALL implement one channel as sub-module game_tick_ch (counter, pending register, tick and sq), instantiated NUM_CH times by a generate loop; tick0_cnt lives in the top.

Verification
REQ-033 SHALL verify: reset release with run=1 and div0=4 -> tick[0] at cycles 4, 8, 12; tick0_cnt = 3 after cycle 12.
REQ-034 SHALL verify: div1=0 and div1=1 with run=1 -> tick[1] high every cycle; with GAME_TICK_SQ_EN defined, sq[1] toggles every cycle.
REQ-035 SHALL verify: write div0=6 at cnt0=1 while div0=4 -> next tick at the old period of 4, then ticks every 6 cycles.
REQ-036 SHALL verify: run low for 10 cycles mid-period -> no ticks, counters frozen; the period resumes and completes with its original remainder.
REQ-037 SHALL verify: restart together with cfg_we ch2 div=3 -> all outputs 0 next cycle and tick[2] after 3 cycles; a write with cfg_ch=3 and NUM_CH=3 is ignored.
REQ-038 SHALL verify: tick0_cnt at 0xFFFF plus one tick[0] -> 0x0000; rst asserted mid-period -> all outputs 0 asynchronously.
